// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Holds the FSM state type, the wrap-around requester search and the owner width rule.
package dff_arb_pkg;

  localparam int MAX_N = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int owner_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of req_v at or above ptr, wrapping within the n live requesters.
  function automatic logic [IDX_W-1:0] rr_next(
    input logic [MAX_N-1:0] req_v,
    input logic [IDX_W-1:0] ptr,
    input int               n
  );
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req_v[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_reg_en.sv
// W-bit D register with write enable, exposing q and its complement q_bar.
// Captures d_i on the rising edge when en_i is high; no backpressure, always accepts.
module dff_reg_en #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] q_bar_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

  assign q_bar_o = ~q_o;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting one of N requesters per cycle write access to a shared register.
// Grant lands 1 cycle after req, data 1 cycle after grant; lock holds the grant for up to MAX_HOLD beats.
module dff_reg_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                req,
  input  logic [N-1:0]                lock,
  input  logic [N*W-1:0]              wdata,
  output logic [N-1:0]                gnt,
  output logic [owner_width(N)-1:0]   owner,
  output logic                        busy,
  output logic                        ack,
  output logic [W-1:0]                q,
  output logic [W-1:0]                q_bar
);

  localparam int OW = owner_width(N);
  localparam int BW = $clog2(MAX_HOLD + 1);

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             ack_q, ack_d;
  logic             wen;
  logic [OW-1:0]    nxt_ptr;
  logic [MAX_N-1:0] req_ext;
  logic [W-1:0]     wr_dat;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign nxt_ptr = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
  assign wr_dat  = wdata[int'(owner_q)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
    wen     = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        beat_d = '0;
        if (|req) begin
          state_d = GRANT;
          owner_d = OW'(rr_next(req_ext, IDX_W'(ptr_q), N));
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << owner_d;
          beat_d  = BW'(1);
        end
      end
      GRANT: begin
        wen   = req[owner_q];
        ack_d = req[owner_q];
        if (lock[owner_q] && req[owner_q] && (beat_q < BW'(MAX_HOLD))) begin
          beat_d = beat_q + BW'(1);
        end else begin
          // Searching from owner+1 lets a lone, still-requesting owner win again last.
          ptr_d = nxt_ptr;
          if (|req) begin
            owner_d = OW'(rr_next(req_ext, IDX_W'(nxt_ptr), N));
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << owner_d;
            beat_d  = BW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            beat_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

  dff_reg_en #(.W(W)) u_reg (
    .clk     (clk),
    .rst     (rst),
    .en_i    (wen),
    .d_i     (wr_dat),
    .q_o     (q),
    .q_bar_o (q_bar)
  );

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign ack   = ack_q;
  assign busy  = (state_q == GRANT);

endmodule
